// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and helpers for the serial pattern detector
//
// Purpose : default pattern width, length-field width derivation and the
//           overlap-mode encodings used by seq_pattern_detector and seq_det_window.
// Ports   : none (package).

package seq_det_pkg;

    // Default maximum pattern length in bits.
    localparam int PAT_W_DEFAULT = 8;

    // cfg_overlap encodings.
    localparam logic OVERLAP     = 1'b1;
    localparam logic NON_OVERLAP = 1'b0;

    // Width needed to hold a length value in the range 0..pat_w inclusive.
    function automatic int len_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_window.sv
// rtl/seq_det_window.sv - masked compare of the bit history against the active pattern
//
// Purpose : combinational check that the newest i_len bits of the history equal
//           the low i_len bits of the pattern. Bits at or above i_len are ignored.
// Ports   : i_hist    [PAT_W-1:0]  history including the bit being sampled (bit 0 newest)
//           i_pattern [PAT_W-1:0]  active pattern (bit 0 is the last bit received)
//           i_len     [LEN_W-1:0]  active length, already clamped to PAT_W
//           o_hit                  1 when i_len != 0 and the masked bits agree

module seq_det_window
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEFAULT,
    parameter int LEN_W = len_width(PAT_W)
) (
    input  logic [PAT_W-1:0] i_hist,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_hit
);

    logic [PAT_W-1:0] w_mask;
    logic [PAT_W-1:0] w_diff;

    // Thermometer mask: ones in positions 0..i_len-1.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < int'(i_len)) begin
                w_mask[i] = 1'b1;
            end
        end
    end

    assign w_diff = (i_hist ^ i_pattern) & w_mask;
    assign o_hit  = (i_len != '0) && (w_diff == '0);

endmodule

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - runtime-programmable serial pattern detector with match counter
//
// Purpose : watches a qualified serial bit stream for a pattern of 1..PAT_W bits,
//           with overlapping or non-overlapping matching and a saturating counter.
// Ports   : clk, rst              clock (rising edge), asynchronous active-high reset
//           in_valid, in_bit      serial input; in_bit sampled only when in_valid is high
//           cfg_load              strobe latching cfg_pattern / cfg_len / cfg_overlap
//           cfg_pattern [PAT_W]   pattern, bit [len-1] received first, bit [0] last
//           cfg_len     [LEN_W]   length, 0 disables, values above PAT_W clamp to PAT_W
//           cfg_overlap           1 = overlapping matches, 0 = non-overlapping
//           cnt_clr               synchronous clear of match_count
//           match                 one-cycle pulse the cycle after the completing bit
//           match_count [CNT_W]   saturating number of matches
//           armed                 enough fresh bits held to be able to match

module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEFAULT,
    parameter int LEN_W = len_width(PAT_W),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Active configuration shadow registers.
    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic             r_overlap;

    // Stream state.
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic             r_match;
    logic [CNT_W-1:0] r_count;

    logic [PAT_W-1:0] w_hist_next;
    logic [LEN_W-1:0] w_fill_next;
    logic [LEN_W-1:0] w_len_clamped;
    logic             w_hit;
    logic             w_match_cond;

    assign w_hist_next   = {r_hist[PAT_W-2:0], in_bit};
    assign w_fill_next   = (r_fill == LEN_MAX) ? r_fill : r_fill + LEN_W'(1);
    assign w_len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

    seq_det_window #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_window (
        .i_hist    (w_hist_next),
        .i_pattern (r_pattern),
        .i_len     (r_len),
        .o_hit     (w_hit)
    );

    // A bit arriving together with cfg_load is discarded, so it can never complete a match.
    assign w_match_cond = in_valid && !cfg_load && w_hit && (w_fill_next >= r_len);

    // Configuration shadow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= OVERLAP;
        end else if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_len     <= w_len_clamped;
            r_overlap <= cfg_overlap;
        end
    end

    // History, fill level and the registered match pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (cfg_load) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (in_valid) begin
            r_hist  <= w_hist_next;
            // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
            r_fill  <= (w_match_cond && (r_overlap == NON_OVERLAP)) ? '0 : w_fill_next;
            r_match <= w_match_cond;
        end else begin
            r_match <= 1'b0;
        end
    end

    // Match counter: the clear wins over a coincident increment; holds at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (cnt_clr) begin
            r_count <= '0;
        end else if (w_match_cond && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign match       = r_match;
    assign match_count = r_count;
    assign armed       = (r_len != '0) && (r_fill >= r_len);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - self-checking bench for seq_pattern_detector

module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       cnt_clr = 1'b0;

    logic        match, armed, match2, armed2;
    logic [15:0] match_count;
    logic [1:0]  match_count2;

    always #5 clk = ~clk;

    seq_pattern_detector #(.PAT_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match), .match_count(match_count), .armed(armed)
    );

    seq_pattern_detector #(.PAT_W(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match2), .match_count(match_count2), .armed(armed2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the bits received since the last clear, newest at the back.
    bit         q[$];
    int         m_len = 0;
    logic [7:0] m_pat = '0;
    bit         m_ovl = 1'b1;
    bit         e_match = 1'b0;
    int         e_cnt = 0;
    int         e_cnt2 = 0;
    bit         e_armed = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                m_len = 0; m_pat = '0; m_ovl = 1'b1;
                e_match = 1'b0; e_cnt = 0; e_cnt2 = 0;
            end else begin
                bit hit;
                hit = 1'b0;
                if (cfg_load) begin
                    m_pat = cfg_pattern;
                    m_len = (int'(cfg_len) > 8) ? 8 : int'(cfg_len);
                    m_ovl = cfg_overlap;
                    q.delete();
                end else if (in_valid) begin
                    q.push_back(in_bit);
                    if (q.size() > 8) void'(q.pop_front());
                    if (m_len != 0 && q.size() >= m_len) begin
                        hit = 1'b1;
                        for (int k = 0; k < m_len; k++)
                            if (q[q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
                    end
                    if (hit && !m_ovl) q.delete();
                end
                e_match = hit;
                if (cnt_clr) begin
                    e_cnt = 0; e_cnt2 = 0;
                end else if (hit) begin
                    if (e_cnt < 65535) e_cnt = e_cnt + 1;
                    if (e_cnt2 < 3) e_cnt2 = e_cnt2 + 1;
                end
            end
            e_armed = (m_len != 0) && (q.size() >= m_len);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("match", int'(match), int'(e_match));
            chk("count", int'(match_count), e_cnt);
            chk("armed", int'(armed), int'(e_armed));
            chk("match_w2", int'(match2), int'(e_match));
            chk("count_w2", int'(match_count2), e_cnt2);
            chk("armed_w2", int'(armed2), int'(e_armed));
        end
    end

    task automatic cyc(input bit v, input bit b, input bit clr = 1'b0);
        in_valid = v; in_bit = b; cnt_clr = clr;
        @(negedge clk);
        in_valid = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o, input bit v = 1'b0);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_load = 1'b1;
        in_valid = v; in_bit = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0; in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i]);
    endtask

    initial begin
        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_match", int'(match), 0);
        chk("rst_count", int'(match_count), 0);
        chk("rst_armed", int'(armed), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1101, overlap
        load(8'b1101, 4'd4, 1'b1);
        cyc(1, 1); cyc(1, 1); cyc(1, 0);
        chk("t1_armed_early", int'(armed), 0);
        chk("t1_match_early", int'(match), 0);
        cyc(1, 1);
        chk("t1_match", int'(match), 1);
        chk("t1_count", int'(match_count), 1);
        chk("t1_armed", int'(armed), 1);
        cyc(0, 0);
        chk("t1_pulse_end", int'(match), 0);

        // 11 over 1111: overlap then non-overlap
        load(8'b11, 4'd2, 1'b1);
        cyc(0, 0, 1);
        send(8'b1111, 4);
        chk("t2_ovl_count", int'(match_count), 3);
        load(8'b11, 4'd2, 1'b0);
        cyc(0, 0, 1);
        send(8'b1111, 4);
        chk("t2_novl_count", int'(match_count), 2);

        // Gaps between pattern bits
        load(8'b1101, 4'd4, 1'b1);
        cyc(0, 0, 1);
        cyc(1, 1); cyc(0, 0); cyc(1, 1); cyc(0, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0);
        chk("t3_idle_match", int'(match), 0);
        cyc(1, 1);
        chk("t3_match", int'(match), 1);
        cyc(0, 0);
        chk("t3_idle_after", int'(match), 0);
        chk("t3_count", int'(match_count), 1);

        // cfg_load mid-pattern (with a discarded coincident bit)
        cyc(0, 0, 1);
        send(8'b110, 3);
        load(8'b1101, 4'd4, 1'b1, 1'b1);
        cyc(1, 1);
        chk("t4_reload_match", int'(match), 0);
        chk("t4_reload_count", int'(match_count), 0);
        load(8'hFF, 4'd0, 1'b1);
        send(8'hFF, 8);
        chk("t4_len0_count", int'(match_count), 0);
        chk("t4_len0_armed", int'(armed), 0);
        load(8'hA5, 4'd15, 1'b1);
        send(8'h52, 7);
        chk("t4_len15_armed7", int'(armed), 0);
        cyc(1, 1);
        chk("t4_len15_match", int'(match), 1);
        chk("t4_len15_count", int'(match_count), 1);

        // Saturation of the 2-bit counter and clear priority
        load(8'b11, 4'd2, 1'b1);
        cyc(0, 0, 1);
        send(8'b111111, 6);
        chk("t5_count16", int'(match_count), 5);
        chk("t5_count2_sat", int'(match_count2), 3);
        cyc(1, 1, 1);
        chk("t5_clr_match", int'(match), 1);
        chk("t5_clr_count", int'(match_count), 0);
        chk("t5_clr_count2", int'(match_count2), 0);

        // Randomized traffic
        for (int blk = 0; blk < 24; blk++) begin
            logic [3:0] l;
            l = (blk % 8 == 7) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
            load(8'($urandom), l, 1'($urandom), 1'($urandom));
            for (int c = 0; c < 100; c++)
                cyc(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 49) == 0));
        end
        chk("rand_count_nonzero", int'(match_count != 0 || e_cnt == 0), 1);

        // Asynchronous reset mid-pattern
        load(8'b1101, 4'd4, 1'b1);
        cyc(1, 1); cyc(1, 1);
        send(8'b11111, 5);
        in_valid = 1'b1; in_bit = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_match", int'(match), 0);
        chk("t6_rst_count", int'(match_count), 0);
        chk("t6_rst_armed", int'(armed), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send(8'b1101, 4);
        chk("t6_disabled_match", int'(match), 0);
        chk("t6_disabled_count", int'(match_count), 0);
        cyc(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
